truth_sweep_ctrl: RTL and testbench
===================================

// Module: truth_sweep_ctrl
// PURPOSE
//   Self-test sequencer for the 3-input truth-table datapath and its 2-stage z delay line.
//   On start, drives all 8 values of x in order. Waits for each result to leave the delay line.
//   Compares the delayed z against TRUTH_TABLE and accumulates an error count and a per-vector fail mask.
//   Sits beside the datapath: x_out feeds the datapath x input, and the datapath's second delay stage feeds z_dly.
// PARAMETERS
//   TRUTH_TABLE  8'b00111001  expected z per vector; bit i = expected z for x==i
//   LATENCY      2            register stages between x and z_dly (>=1)
// PORTS
//   clock      in   1  single clock, all state updates on posedge
//   reset      in   1  synchronous, active-high
//   start      in   1  request a sweep; sampled in IDLE/DONE only
//   z_dly      in   1  datapath z after LATENCY register stages
//   x_out      out  3  stimulus vector to datapath (registered)
//   busy       out  1  high while sweep in progress
//   done       out  1  high in DONE until next start or reset
//   pass       out  1  valid with done: 1 iff err_count==0
//   err_count  out  4  mismatches in last sweep, 0..8
//   fail_mask  out  8  bit i set iff vector i mismatched
// BEHAVIOUR
//   - Reset: state=IDLE, x_out=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, wait counter=0.
//   - Reset mid-sweep aborts the sweep. All outputs take their reset values at the next edge.
//   - FSM states: IDLE -> RUN -> DONE; DONE -> RUN on start; no other transitions.
//   - Start handling:
//     - start=1 in IDLE or DONE at edge e0: state=RUN, busy=1, done=0, x_out=0, wcnt=0.
//     - At the same edge e0, err_count=0 and fail_mask=0.
//     - start while busy is ignored and has no effect on the sweep.
//   - Sequential mode (default), one vector per LATENCY+1 cycles:
//     - wcnt increments each cycle while RUN.
//     - At an edge where wcnt==LATENCY: sample z_dly and compare it to TRUTH_TABLE[x_out].
//     - On mismatch: err_count+1 and fail_mask[x_out]=1.
//     - If x_out==7: go to DONE. Otherwise x_out+1 and wcnt=0.
//     - With LATENCY=2, vector i is sampled at edge e0+3i+3.
//     - done=1 and busy=0 after edge e0+24. pass is updated at that same edge.
//   - x_out holds 7 in DONE and is never changed outside RUN (no wrap to 0 except on start/reset).
//   - err_count cannot exceed 8; its width is sized so it does not saturate.
//   - Compare uses the x index that produced the sample, never the current x_out (this matters in pipelined mode).
// CONFIGURATION
//   SWEEP_PIPELINE_EN defined:
//     - x_out advances every cycle in RUN: vector i is driven from edge e0+i.
//     - A LATENCY+1 deep shift register carries (valid, index). A sample taken at edge e0+i+LATENCY+1 checks vector i.
//     - With LATENCY=2, done is set at edge e0+10.
//     - Results (err_count, fail_mask, pass) are identical to sequential mode.
//   SWEEP_PIPELINE_EN undefined:
//     - Sequential mode as above. No shift register is instantiated.
//   Port list is identical in both builds.
// STRUCTURE
//   Shared package truth_sweep_pkg:
//     - state enum/localparams ST_IDLE, ST_RUN, ST_DONE
//     - NUM_VEC=8
//     - default TRUTH_TABLE constant (shared with the datapath)
//   One natural sub-module: sweep_result_acc, holding the err_count/fail_mask/pass accumulator.
//     - Inputs: clear, sample_en, idx, z, expected.
//     - Reused by both modes.
//   FSM and wait/issue counters stay in the top module.
// TESTING (bench instantiates the real datapath with LATENCY=2)
//   1 Good datapath, start pulse at e0 -> done=1 after e0+24; pass=1, err_count=0, fail_mask=8'h00.
//   2 z_dly forced 0 -> err_count=4, fail_mask=8'b00111001, pass=0.
//   3 z_dly forced 1 -> err_count=4, fail_mask=8'b11000110, pass=0.
//   4 start held high during RUN, cycles 1..20 -> single sweep, done still at e0+24, results as in test 1.
//   5 reset at cycle 10 of a sweep -> next edge: x_out=0, busy=0, done=0, err_count=0, fail_mask=0; later start sweeps normally.
//   6 SWEEP_PIPELINE_EN build, tests 1-3 -> done after e0+10; x_out steps 0..7 on consecutive cycles; identical results.

Source files
------------

// File: rtl/truth_sweep_pkg.sv
// Shared constants and types for the truth-table self-test sequencer.
// The default truth table is also the one the datapath implements.
package truth_sweep_pkg;

  localparam int unsigned NUM_VEC = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned ERR_W   = 4;   // holds 0..NUM_VEC without saturating

  localparam logic [NUM_VEC-1:0] DEFAULT_TRUTH_TABLE = 8'b0011_1001;
  localparam logic [IDX_W-1:0]   LAST_IDX            = 3'(NUM_VEC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sweep_state_e;

endpackage

// File: rtl/truth_sweep_ctrl_acc.sv
// sweep_result_acc: accumulates mismatches of one sweep.
// clear restarts the tally; finish latches pass including the final sample.
module sweep_result_acc
  import truth_sweep_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               sample_en,
  input  logic               finish,
  input  logic [IDX_W-1:0]   idx,
  input  logic               z,
  input  logic               expected,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count,
  output logic [NUM_VEC-1:0] fail_mask
);

  logic               mismatch;
  logic               pass_q;
  logic [ERR_W-1:0]   err_q;
  logic [NUM_VEC-1:0] mask_q;

  assign mismatch = sample_en && (z != expected);

  // Tally errors per sweep; pass reflects the count after the last sample.
  always_ff @(posedge clock) begin
    if (reset) begin
      pass_q <= 1'b0;
      err_q  <= '0;
      mask_q <= '0;
    end else if (clear) begin
      pass_q <= 1'b0;
      err_q  <= '0;
      mask_q <= '0;
    end else begin
      if (mismatch) begin
        err_q       <= err_q + ERR_W'(1);
        mask_q[idx] <= 1'b1;
      end
      if (finish) begin
        pass_q <= (err_q == '0) && !mismatch;
      end
    end
  end

  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_mask = mask_q;

endmodule

// File: rtl/truth_sweep_ctrl.sv
// truth_sweep_ctrl: drives all 8 x vectors into the truth-table datapath,
// checks the delayed z against TRUTH_TABLE and reports pass/err/mask.
// Build option SWEEP_PIPELINE_EN: issue one vector per cycle and track the
// in-flight indices in a (valid, index) shift register; otherwise one vector
// per LATENCY+1 cycles using a wait counter.
module truth_sweep_ctrl
  import truth_sweep_pkg::*;
#(
  parameter logic [NUM_VEC-1:0] TRUTH_TABLE = DEFAULT_TRUTH_TABLE,
  parameter int unsigned        LATENCY     = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               z_dly,
  output logic [IDX_W-1:0]   x_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count,
  output logic [NUM_VEC-1:0] fail_mask
);

  sweep_state_e     state_q;
  logic [IDX_W-1:0] x_out_q;
  logic             busy_q;
  logic             done_q;

  logic             start_go;
  logic             sample_en;
  logic [IDX_W-1:0] sample_idx;
  logic             last_sample;
  logic             expected;

`ifdef SWEEP_PIPELINE_EN
  logic             issue;
  logic [IDX_W-1:0] issue_idx;
  logic [LATENCY:0] pipe_vld_q;
  logic [IDX_W-1:0] pipe_idx_q [LATENCY+1];
`else
  localparam int unsigned WCNT_W = $clog2(LATENCY + 1);
  logic [WCNT_W-1:0] wcnt_q;
`endif

  // Decode which vector (if any) is being checked at the coming edge.
  // NOTE: every signal gets a default first so no latch can be inferred.
  always_comb begin
    start_go   = start && (state_q != ST_RUN);
    sample_en  = 1'b0;
    sample_idx = x_out_q;
`ifdef SWEEP_PIPELINE_EN
    issue      = start_go || ((state_q == ST_RUN) && (x_out_q != LAST_IDX));
    issue_idx  = start_go ? '0 : x_out_q + 3'd1;
    sample_en  = (state_q == ST_RUN) && pipe_vld_q[LATENCY];
    sample_idx = pipe_idx_q[LATENCY];
`else
    sample_en  = (state_q == ST_RUN) && (wcnt_q == WCNT_W'(LATENCY));
`endif
    last_sample = sample_en && (sample_idx == LAST_IDX);
    expected    = TRUTH_TABLE[sample_idx];
  end

  // Sweep FSM with registered stimulus and status outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_out_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifndef SWEEP_PIPELINE_EN
      wcnt_q  <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_go) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            x_out_q <= '0;
`ifndef SWEEP_PIPELINE_EN
            wcnt_q  <= '0;
`endif
          end
        end
        ST_RUN: begin
`ifdef SWEEP_PIPELINE_EN
          if (x_out_q != LAST_IDX) x_out_q <= x_out_q + 3'd1;
`else
          wcnt_q <= wcnt_q + WCNT_W'(1);
          if (sample_en) begin
            wcnt_q <= '0;
            if (x_out_q != LAST_IDX) x_out_q <= x_out_q + 3'd1;
          end
`endif
          if (last_sample) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef SWEEP_PIPELINE_EN
  // Carry each issued index alongside its result through the delay line.
  // NOTE: only the valid bits are reset; index entries are don't-care
  // until their valid bit arrives.
  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_vld_q <= '0;
    end else begin
      pipe_vld_q <= {pipe_vld_q[LATENCY-1:0], issue};
    end
    pipe_idx_q[0] <= issue_idx;
    for (int s = 1; s <= LATENCY; s++) begin
      pipe_idx_q[s] <= pipe_idx_q[s-1];
    end
  end
`endif

  sweep_result_acc u_acc (
    .clock     (clock),
    .reset     (reset),
    .clear     (start_go),
    .sample_en (sample_en),
    .finish    (last_sample),
    .idx       (sample_idx),
    .z         (z_dly),
    .expected  (expected),
    .pass      (pass),
    .err_count (err_count),
    .fail_mask (fail_mask)
  );

  assign x_out = x_out_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_truth_sweep_ctrl.sv
// Self-checking bench for truth_sweep_ctrl with a 2-stage datapath model.
module tb_truth_sweep_ctrl;

  localparam logic [7:0] TT = 8'b0011_1001;
`ifdef SWEEP_PIPELINE_EN
  localparam int DONE_EDGE = 10;
`else
  localparam int DONE_EDGE = 24;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       z_dly;
  logic [2:0] x_out;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [7:0] fail_mask;

  // datapath model: z = TT[x], two register stages; z_mode 1/2 forces 0/1
  int   z_mode = 0;
  logic z_s1 = 1'b0, z_s2 = 1'b0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    z_s1 <= TT[x_out];
    z_s2 <= z_s1;
  end

  assign z_dly = (z_mode == 1) ? 1'b0 : (z_mode == 2) ? 1'b1 : z_s2;

  truth_sweep_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .z_dly     (z_dly),
    .x_out     (x_out),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_mask (fail_mask)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int exp_x(input int k);
    int v;
`ifdef SWEEP_PIPELINE_EN
    v = k;
`else
    v = k / 3;
`endif
    return (v > 7) ? 7 : v;
  endfunction

  typedef struct {
    int         mode;
    int         hold;
    logic [3:0] err;
    logic [7:0] mask;
    logic       pass;
  } vec_t;

  vec_t vecs[5];

  // start pulse at edge e0, optional hold of start over edges e0+1..e0+hold
  task automatic run_sweep(input string tag, input vec_t v);
    bit x_ok, done_ok, busy_ok;
    z_mode = v.mode;
    start  = 1'b1;
    tick();  // e0
    check({tag, " e0 busy"}, busy, 1);
    check({tag, " e0 done"}, done, 0);
    check({tag, " e0 x_out"}, x_out, 0);
    check({tag, " e0 err cleared"}, err_count, 0);
    check({tag, " e0 mask cleared"}, fail_mask, 0);
    x_ok = 1; done_ok = 1; busy_ok = 1;
    for (int k = 1; k <= DONE_EDGE; k++) begin
      start = (k <= v.hold);
      tick();
      if (x_out !== 3'(exp_x(k))) x_ok = 0;
      if (done !== (k == DONE_EDGE)) done_ok = 0;
      if (busy !== (k != DONE_EDGE)) busy_ok = 0;
    end
    start = 1'b0;
    check({tag, " x_out sequence"}, x_ok, 1);
    check({tag, " done timing"}, done_ok, 1);
    check({tag, " busy timing"}, busy_ok, 1);
    check({tag, " err_count"}, err_count, v.err);
    check({tag, " fail_mask"}, fail_mask, v.mask);
    check({tag, " pass"}, pass, v.pass);
    tick();
    check({tag, " done held"}, done, 1);
    check({tag, " x_out held"}, x_out, 7);
  endtask

  initial begin
    vecs[0] = '{mode: 0, hold: 0,  err: 4'd0, mask: 8'h00,        pass: 1'b1};
    vecs[1] = '{mode: 1, hold: 0,  err: 4'd4, mask: 8'b0011_1001, pass: 1'b0};
    vecs[2] = '{mode: 2, hold: 0,  err: 4'd4, mask: 8'b1100_0110, pass: 1'b0};
    vecs[3] = '{mode: 0, hold: 20, err: 4'd0, mask: 8'h00,        pass: 1'b1};
    vecs[4] = '{mode: 0, hold: 0,  err: 4'd0, mask: 8'h00,        pass: 1'b1};

    repeat (2) tick();
    check("reset x_out", x_out, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset pass", pass, 0);
    check("reset err", err_count, 0);
    check("reset mask", fail_mask, 0);
    reset = 1'b0;
    tick();
    check("idle no start busy", busy, 0);

    for (int i = 0; i < 5; i++) begin
      run_sweep($sformatf("vec%0d", i), vecs[i]);
    end

    // reset 10 cycles into a failing sweep aborts it
    z_mode = 1;
    start  = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    check("abort x_out", x_out, 0);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort pass", pass, 0);
    check("abort err", err_count, 0);
    check("abort mask", fail_mask, 0);
    reset = 1'b0;
    tick();
    tick();
    check("post abort idle", busy, 0);
    run_sweep("after_abort", vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
